// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle for the 3x3 window generator.
// Latency: none (wires only).
// Backpressure: none; the producer paces pixels with din_valid, the consumer must take every window.
interface conv_window_gen_if #(
    parameter int DW = 8,
    parameter int CW = 5
);
    logic               start;
    logic               din_valid;
    logic [DW-1:0]      datain;
    logic               busy;
    logic               win_valid;
    logic [9*DW-1:0]    window;
    logic [CW-1:0]      win_row;
    logic [CW-1:0]      win_col;
    logic               done;

    // Pixel source / window sink side.
    modport master (
        output start, din_valid, datain,
        input  busy, win_valid, window, win_row, win_col, done
    );

    // Window generator side.
    modport slave (
        input  start, din_valid, datain,
        output busy, win_valid, window, win_row, win_col, done
    );
endinterface

// File: rtl/conv_window_gen.sv
// Turns a raster N x N pixel stream into parallel 3x3 windows for the convolution core.
// Latency: a window appears exactly 1 cycle after the pixel completing it is accepted.
// Backpressure: none; din_valid gaps freeze all state, windows are never stalled.
module conv_window_gen #(
    parameter int N  = 28,
    parameter int DW = 8,
    parameter int CW = 5
) (
    input  logic                clk,
    input  logic                rst,
    conv_window_gen_if.slave    bus
);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] TWO  = CW'(2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      row;
    logic [CW-1:0]      col;
    logic               accept;
    logic               emit;
    logic               last_pix;

    // Row r-1 and row r-2 history as shift chains; tail entry is the pixel
    // directly above (lb1) or two above (lb2) the incoming one.
    logic [DW-1:0]      lb1 [N];
    logic [DW-1:0]      lb2 [N];

    // 3x3 working window [row offset][col offset] and its post-shift view.
    logic [DW-1:0]      win     [3][3];
    logic [DW-1:0]      win_nxt [3][3];
    logic [9*DW-1:0]    win_pack;

    logic               win_valid_q;
    logic               done_q;
    logic [9*DW-1:0]    window_q;
    logic [CW-1:0]      win_row_q;
    logic [CW-1:0]      win_col_q;

    // Next-state and accept/emit decode; start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        accept    = (state == RUN) && bus.din_valid;
        last_pix  = accept && (row == LAST) && (col == LAST);
        emit      = accept && (row >= TWO) && (col >= TWO);
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN:  if (last_pix)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                row <= '0;
                col <= '0;
            end
        end else if (accept) begin
            if (col == LAST) begin
                col <= '0;
                row <= (row == LAST) ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // New window = old window shifted left by one column plus the new column
    // (two rows up, one row up, current pixel).
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            win_nxt[i][0] = win[i][1];
            win_nxt[i][1] = win[i][2];
        end
        win_nxt[0][2] = lb2[N-1];
        win_nxt[1][2] = lb1[N-1];
        win_nxt[2][2] = bus.datain;
        win_pack = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_pack[DW*(3*i+j) +: DW] = win_nxt[i][j];
            end
        end
    end

    // Line buffers and working window are pure data; they need no reset because
    // a window is only emitted once two rows of the current frame are buffered.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[0] <= bus.datain;
            lb2[0] <= lb1[N-1];
            for (int k = 1; k < N; k++) begin
                lb1[k] <= lb1[k-1];
                lb2[k] <= lb2[k-1];
            end
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= win_nxt[i][j];
                end
            end
        end
    end

    // Output registers: update only on an emitting accept, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
            window_q    <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            win_valid_q <= emit;
            done_q      <= last_pix;
            if (emit) begin
                window_q  <= win_pack;
                win_row_q <= row - TWO;
                win_col_q <= col - TWO;
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.win_valid = win_valid_q;
    assign bus.done      = done_q;
    assign bus.window    = window_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;
    localparam int N = 28;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_window_gen_if #(.DW(8), .CW(5)) bus ();
    conv_window_gen_if #(.DW(8), .CW(2)) sbus ();

    conv_window_gen #(.N(N), .DW(8), .CW(5)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    conv_window_gen #(.N(4), .DW(8), .CW(2)) u_small (.clk(clk), .rst(rst), .bus(sbus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          fill;       // 0 = ramp, 1 = all ones
        bit          gapped;
        int          idle_junk;
        int          mid_start;
        int          exp_count;
        logic [71:0] exp_first;
        logic [7:0]  exp_last_k8;
    } scen_t;

    typedef struct {
        int          row;
        int          col;
        logic [71:0] w;
        bit          done;
    } swin_t;

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int fill, input int r, input int c);
        if (fill == 0) return 8'((r * N + c) % 256);
        return 8'hFF;
    endfunction

    function automatic logic [71:0] exp_win(input int fill, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = pix(fill, r - 2 + i, c - 2 + j);
        return w;
    endfunction

    function automatic logic [71:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Called at a negedge; start edge happens at the following posedge.
    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1'b1);
        check("no_win_at_start", bus.win_valid, 1'b0);
    endtask

    // Drives one frame from a negedge, checking every cycle's outputs against
    // the expected result of the previous edge. Ends at the done negedge, or
    // after abort_after pixels if that is positive.
    task automatic run_pixels(input int fill, input bit gapped, input int mid_start,
                              input int abort_after, input bit start_at_end,
                              output int nwin, output logic [71:0] first_w,
                              output logic [71:0] last_w, output bit done_seen);
        int p = 0;
        int cyc = 0;
        int r, c;
        bit pend_vld = 0;
        bit pend_done = 0;
        bit have_held = 0;
        int pend_r = 0;
        int pend_c = 0;
        logic [71:0] pend_w = '0;
        logic [71:0] held_w = '0;
        nwin = 0; first_w = '0; last_w = '0; done_seen = 0;
        while (1) begin
            if (cyc > 0) begin
                check("win_valid", bus.win_valid, pend_vld);
                check("done", bus.done, pend_done);
                check("busy", bus.busy, !pend_done);
                if (bus.win_valid) begin
                    nwin++;
                    if (nwin == 1) first_w = bus.window;
                    last_w = bus.window;
                    if (bus.done) done_seen = 1;
                end
                if (pend_vld) begin
                    check("window", bus.window, pend_w);
                    check("win_row", bus.win_row, pend_r);
                    check("win_col", bus.win_col, pend_c);
                    held_w = pend_w;
                    have_held = 1;
                end else if (have_held) begin
                    check("window_hold", bus.window, held_w);
                end
            end
            if (pend_done || (abort_after > 0 && p == abort_after)) break;
            pend_vld = 0;
            pend_done = 0;
            bus.start = (mid_start >= 0 && p == mid_start);
            if (gapped && (cyc % 2 == 1)) begin
                bus.din_valid = 1'b0;
                bus.datain = 8'h5A;
            end else begin
                r = p / N;
                c = p % N;
                bus.din_valid = 1'b1;
                bus.datain = pix(fill, r, c);
                pend_vld = (r >= 2) && (c >= 2);
                pend_w = exp_win(fill, r, c);
                pend_r = r - 2;
                pend_c = c - 2;
                pend_done = (p == N * N - 1);
                p++;
            end
            cyc++;
            @(negedge clk);
        end
        bus.din_valid = 1'b0;
        bus.start = start_at_end;
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_busy"}, bus.busy, 1'b0);
        check({nm, "_win_valid"}, bus.win_valid, 1'b0);
        check({nm, "_done"}, bus.done, 1'b0);
    endtask

    scen_t tbl[3];
    swin_t stbl[4];
    logic [71:0] sq_w[$];
    int sq_r[$];
    int sq_c[$];
    bit sq_d[$];

    initial begin
        int nwin;
        logic [71:0] fw, lw;
        bit ds;
        int sdone;

        tbl[0] = '{0, 1'b0, 0,  -1,  676, pack9(0, 1, 2, 28, 29, 30, 56, 57, 58), 8'd15};
        tbl[1] = '{0, 1'b1, 0,  -1,  676, pack9(0, 1, 2, 28, 29, 30, 56, 57, 58), 8'd15};
        tbl[2] = '{0, 1'b0, 10, 100, 676, pack9(0, 1, 2, 28, 29, 30, 56, 57, 58), 8'd15};

        stbl[0] = '{0, 0, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10),     1'b0};
        stbl[1] = '{0, 1, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11),    1'b0};
        stbl[2] = '{1, 0, pack9(4, 5, 6, 8, 9, 10, 12, 13, 14),  1'b0};
        stbl[3] = '{1, 1, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15), 1'b1};

        bus.start = 0; bus.din_valid = 0; bus.datain = 0;
        sbus.start = 0; sbus.din_valid = 0; sbus.datain = 0;

        // Reset state
        #12;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_win_valid", bus.win_valid, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_window", bus.window, 72'h0);
        check("rst_win_row", bus.win_row, 0);
        check("rst_win_col", bus.win_col, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven frame scenarios
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < tbl[s].idle_junk; k++) begin
                bus.din_valid = 1'b1;
                bus.datain = 8'hAA;
                @(negedge clk);
                check("idle_junk_busy", bus.busy, 1'b0);
                check("idle_junk_win", bus.win_valid, 1'b0);
            end
            do_start();
            run_pixels(tbl[s].fill, tbl[s].gapped, tbl[s].mid_start, -1, 1'b0, nwin, fw, lw, ds);
            check($sformatf("s%0d_count", s), nwin, tbl[s].exp_count);
            check($sformatf("s%0d_first", s), fw, tbl[s].exp_first);
            check($sformatf("s%0d_last_k8", s), lw[71:64], tbl[s].exp_last_k8);
            check($sformatf("s%0d_done_with_last", s), ds, 1'b1);
            @(negedge clk);
            check_idle("after_frame");
        end

        // Reset mid-frame, asserted between edges
        do_start();
        run_pixels(0, 1'b0, -1, 300, 1'b0, nwin, fw, lw, ds);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_win_valid", bus.win_valid, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_window", bus.window, 72'h0);
        check("abort_win_row", bus.win_row, 0);
        check("abort_win_col", bus.win_col, 0);
        @(negedge clk);
        check("abort_no_done", bus.done, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort_idle");
        do_start();
        run_pixels(0, 1'b0, -1, -1, 1'b0, nwin, fw, lw, ds);
        check("post_abort_count", nwin, 676);
        check("post_abort_first", fw, pack9(0, 1, 2, 28, 29, 30, 56, 57, 58));
        check("post_abort_last_k8", lw[71:64], 8'd15);
        @(negedge clk);

        // Back-to-back frames: start in the done cycle, second frame all ones
        do_start();
        run_pixels(0, 1'b0, -1, -1, 1'b1, nwin, fw, lw, ds);
        check("b2b_f1_count", nwin, 676);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", bus.busy, 1'b1);
        run_pixels(1, 1'b0, -1, -1, 1'b0, nwin, fw, lw, ds);
        check("b2b_f2_count", nwin, 676);
        check("b2b_f2_first", fw, {9{8'hFF}});
        check("b2b_f2_last", lw, {9{8'hFF}});
        check("b2b_f2_done", ds, 1'b1);
        @(negedge clk);
        check_idle("b2b_end");

        // Small N=4 instance
        sbus.start = 1'b1;
        @(negedge clk);
        sbus.start = 1'b0;
        sdone = 0;
        for (int p = 0; p < 19; p++) begin
            sbus.din_valid = (p < 16);
            sbus.datain = 8'(p);
            @(negedge clk);
            if (sbus.done) sdone++;
            if (sbus.win_valid) begin
                sq_w.push_back(sbus.window);
                sq_r.push_back(int'(sbus.win_row));
                sq_c.push_back(int'(sbus.win_col));
                sq_d.push_back(sbus.done);
            end
        end
        sbus.din_valid = 1'b0;
        check("small_count", sq_w.size(), 4);
        check("small_done_count", sdone, 1);
        check("small_busy_end", sbus.busy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k < sq_w.size()) begin
                check($sformatf("small_w%0d_row", k), sq_r[k], stbl[k].row);
                check($sformatf("small_w%0d_col", k), sq_c[k], stbl[k].col);
                check($sformatf("small_w%0d_win", k), sq_w[k], stbl[k].w);
                check($sformatf("small_w%0d_done", k), sq_d[k], stbl[k].done);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
